mul_pipeline: RTL and testbench

Three-stage pipelined RV32M multiplier executing MUL, MULH, MULHSU and MULHU. It accepts one operation per cycle from the EX stage and never stalls. It exports per-stage valid flags and destination tags (P1/P2/P3 `_RegMul`, `_Rd`) consumed by the hazard detection unit, and drives a dedicated multiplier writeback request into the register-file write mux.

---
 rtl/mul_pipeline_if.sv | 36 +++
 rtl/mul_pipeline.sv | 178 +++++++++++++++++
 tb/tb_mul_pipeline.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_pipeline_if.sv
// mul_pipeline_if: issue bus from EX plus the stage-status and writeback bus of the pipelined multiplier.
// master = EX/hazard/writeback side, slave = multiplier.
interface mul_pipeline_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  Mul_Valid;
  logic [1:0]            Mul_Funct3;
  logic [DATA_WIDTH-1:0] Mul_Rs1;
  logic [DATA_WIDTH-1:0] Mul_Rs2;
  logic [ADDR_WIDTH-1:0] Mul_Rd;

  logic                  P1_RegMul;
  logic                  P2_RegMul;
  logic                  P3_RegMul;
  logic [ADDR_WIDTH-1:0] P1_Rd;
  logic [ADDR_WIDTH-1:0] P2_Rd;
  logic [ADDR_WIDTH-1:0] P3_Rd;
  logic                  Mul_WE;
  logic [ADDR_WIDTH-1:0] Mul_WB_Rd;
  logic [DATA_WIDTH-1:0] Mul_WB_Data;
  logic                  Mul_Busy;
  logic [1:0]            Mul_InFlight;

  modport master (
    output Mul_Valid, Mul_Funct3, Mul_Rs1, Mul_Rs2, Mul_Rd,
    input  P1_RegMul, P2_RegMul, P3_RegMul, P1_Rd, P2_Rd, P3_Rd,
    input  Mul_WE, Mul_WB_Rd, Mul_WB_Data, Mul_Busy, Mul_InFlight
  );

  modport slave (
    input  Mul_Valid, Mul_Funct3, Mul_Rs1, Mul_Rs2, Mul_Rd,
    output P1_RegMul, P2_RegMul, P3_RegMul, P1_Rd, P2_Rd, P3_Rd,
    output Mul_WE, Mul_WB_Rd, Mul_WB_Data, Mul_Busy, Mul_InFlight
  );
endinterface

// File: rtl/mul_pipeline.sv
// mul_pipeline: three-stage RV32M multiplier (MUL/MULH/MULHSU/MULHU), one issue per cycle, never stalls.
// Define MUL_HIGH_EN to build the upper-product path; without it every funct3 returns product[31:0].
module mul_pipeline #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic           clk,
  input logic           reset,
  mul_pipeline_if.slave bus
);

  localparam logic [1:0] F_MUL = 2'b00;
`ifdef MUL_HIGH_EN
  localparam logic [1:0] F_MULHSU = 2'b10;
  localparam logic [1:0] F_MULHU  = 2'b11;
  localparam int OP_W = 33;
  localparam int XP_W = 48;
`else
  // Low-word-only build: operand extension cannot affect product[31:0], so operands stay 32 bits.
  localparam int OP_W = 32;
  localparam int XP_W = 16;
`endif
  localparam int HI_W = OP_W - 16;

  function automatic logic [1:0] count_valid(input logic v1, input logic v2, input logic v3);
    count_valid = {1'b0, v1} + {1'b0, v2} + {1'b0, v3};
  endfunction

  logic                  p1_valid_d, p1_valid_q;
  logic [ADDR_WIDTH-1:0] p1_rd_d, p1_rd_q;
  logic [1:0]            p1_funct3_d, p1_funct3_q;
  logic [OP_W-1:0]       p1_op_a_d, p1_op_a_q;
  logic [OP_W-1:0]       p1_op_b_d, p1_op_b_q;

  logic                  p2_valid_d, p2_valid_q;
  logic [ADDR_WIDTH-1:0] p2_rd_d, p2_rd_q;
  logic [1:0]            p2_funct3_d, p2_funct3_q;
  logic [31:0]           p2_pp_ll_d, p2_pp_ll_q;
  logic [XP_W-1:0]       p2_pp_hl_d, p2_pp_hl_q;
  logic [XP_W-1:0]       p2_pp_lh_d, p2_pp_lh_q;
`ifdef MUL_HIGH_EN
  logic [31:0]           p2_pp_hh_d, p2_pp_hh_q;
  logic                  a_sext_s, b_sext_s;
  logic [63:0]           sum_s;
`endif

  logic                  p3_valid_d, p3_valid_q;
  logic [ADDR_WIDTH-1:0] p3_rd_d, p3_rd_q;
  logic [DATA_WIDTH-1:0] p3_data_d, p3_data_q;
  logic                  we_d, we_q;
  logic                  busy_d, busy_q;
  logic [1:0]            inflight_d, inflight_q;

  logic [HI_W-1:0]       a_hi_s, b_hi_s;
  logic [15:0]           a_lo_s, b_lo_s;
  logic [31:0]           res_lo_s, res_hi_s;

  // P1 next state: capture the issue and extend operands according to funct3.
  always_comb begin
    p1_valid_d  = bus.Mul_Valid;
    p1_rd_d     = bus.Mul_Rd;
    p1_funct3_d = bus.Mul_Funct3;
`ifdef MUL_HIGH_EN
    case (bus.Mul_Funct3)
      F_MULHSU: begin a_sext_s = 1'b1; b_sext_s = 1'b0; end
      F_MULHU:  begin a_sext_s = 1'b0; b_sext_s = 1'b0; end
      default:  begin a_sext_s = 1'b1; b_sext_s = 1'b1; end
    endcase
    p1_op_a_d = {a_sext_s & bus.Mul_Rs1[DATA_WIDTH-1], bus.Mul_Rs1};
    p1_op_b_d = {b_sext_s & bus.Mul_Rs2[DATA_WIDTH-1], bus.Mul_Rs2};
`else
    p1_op_a_d = bus.Mul_Rs1;
    p1_op_b_d = bus.Mul_Rs2;
`endif
  end

  // P2 next state: signed-hi / unsigned-lo partial products, kept only as wide as the used sum bits.
  always_comb begin
    a_hi_s      = p1_op_a_q[OP_W-1:16];
    b_hi_s      = p1_op_b_q[OP_W-1:16];
    a_lo_s      = p1_op_a_q[15:0];
    b_lo_s      = p1_op_b_q[15:0];
    p2_valid_d  = p1_valid_q;
    p2_rd_d     = p1_rd_q;
    p2_funct3_d = p1_funct3_q;
    p2_pp_ll_d  = {16'h0000, a_lo_s} * {16'h0000, b_lo_s};
`ifdef MUL_HIGH_EN
    p2_pp_hl_d  = {{31{a_hi_s[HI_W-1]}}, a_hi_s} * {32'h0000_0000, b_lo_s};
    p2_pp_lh_d  = {32'h0000_0000, a_lo_s} * {{31{b_hi_s[HI_W-1]}}, b_hi_s};
    p2_pp_hh_d  = {{15{a_hi_s[HI_W-1]}}, a_hi_s} * {{15{b_hi_s[HI_W-1]}}, b_hi_s};
`else
    p2_pp_hl_d  = a_hi_s * b_lo_s;
    p2_pp_lh_d  = a_lo_s * b_hi_s;
`endif
  end

  // P3 next state: sum shifted partials, pick the result word, precompute status outputs.
  always_comb begin
`ifdef MUL_HIGH_EN
    sum_s    = {p2_pp_hh_q, 32'h0000_0000} + {p2_pp_hl_q, 16'h0000}
             + {p2_pp_lh_q, 16'h0000} + {32'h0000_0000, p2_pp_ll_q};
    res_lo_s = sum_s[31:0];
    res_hi_s = sum_s[63:32];
`else
    res_lo_s = p2_pp_ll_q + {p2_pp_hl_q, 16'h0000} + {p2_pp_lh_q, 16'h0000};
    res_hi_s = res_lo_s;
`endif
    case (p2_funct3_q)
      F_MUL:   p3_data_d = res_lo_s;
      default: p3_data_d = res_hi_s;
    endcase
    p3_valid_d = p2_valid_q;
    p3_rd_d    = p2_rd_q;
    we_d       = p2_valid_q && (p2_rd_q != {ADDR_WIDTH{1'b0}});
    busy_d     = p1_valid_d | p2_valid_d | p3_valid_d;
    inflight_d = count_valid(p1_valid_d, p2_valid_d, p3_valid_d);
  end

  // Stage registers advance every cycle; reset flushes everything, including a same-edge issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_valid_q  <= 1'b0;
      p1_rd_q     <= {ADDR_WIDTH{1'b0}};
      p1_funct3_q <= 2'b00;
      p1_op_a_q   <= {OP_W{1'b0}};
      p1_op_b_q   <= {OP_W{1'b0}};
      p2_valid_q  <= 1'b0;
      p2_rd_q     <= {ADDR_WIDTH{1'b0}};
      p2_funct3_q <= 2'b00;
      p2_pp_ll_q  <= 32'h0000_0000;
      p2_pp_hl_q  <= {XP_W{1'b0}};
      p2_pp_lh_q  <= {XP_W{1'b0}};
`ifdef MUL_HIGH_EN
      p2_pp_hh_q  <= 32'h0000_0000;
`endif
      p3_valid_q  <= 1'b0;
      p3_rd_q     <= {ADDR_WIDTH{1'b0}};
      p3_data_q   <= {DATA_WIDTH{1'b0}};
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      inflight_q  <= 2'b00;
    end else begin
      p1_valid_q  <= p1_valid_d;
      p1_rd_q     <= p1_rd_d;
      p1_funct3_q <= p1_funct3_d;
      p1_op_a_q   <= p1_op_a_d;
      p1_op_b_q   <= p1_op_b_d;
      p2_valid_q  <= p2_valid_d;
      p2_rd_q     <= p2_rd_d;
      p2_funct3_q <= p2_funct3_d;
      p2_pp_ll_q  <= p2_pp_ll_d;
      p2_pp_hl_q  <= p2_pp_hl_d;
      p2_pp_lh_q  <= p2_pp_lh_d;
`ifdef MUL_HIGH_EN
      p2_pp_hh_q  <= p2_pp_hh_d;
`endif
      p3_valid_q  <= p3_valid_d;
      p3_rd_q     <= p3_rd_d;
      p3_data_q   <= p3_data_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      inflight_q  <= inflight_d;
    end
  end

  assign bus.P1_RegMul    = p1_valid_q;
  assign bus.P2_RegMul    = p2_valid_q;
  assign bus.P3_RegMul    = p3_valid_q;
  assign bus.P1_Rd        = p1_rd_q;
  assign bus.P2_Rd        = p2_rd_q;
  assign bus.P3_Rd        = p3_rd_q;
  assign bus.Mul_WE       = we_q;
  assign bus.Mul_WB_Rd    = p3_rd_q;
  assign bus.Mul_WB_Data  = p3_data_q;
  assign bus.Mul_Busy     = busy_q;
  assign bus.Mul_InFlight = inflight_q;

endmodule

// File: tb/tb_mul_pipeline.sv
// tb_mul_pipeline: directed vectors with literal expectations plus an issue-history model
// checked against every stage output on each falling edge.
module tb_mul_pipeline;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  mul_pipeline_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  mul_pipeline #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Issue history indexed by rising-edge number; an op is in stage k if issued k-1 edges ago
  // and no reset edge has occurred since.
  int cyc = 0;
  int last_rst = 0;
  bit iv [0:2047];
  logic [4:0] ird [0:2047];
  logic [31:0] ires [0:2047];

  function automatic logic [31:0] ref_res(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_HIGH_EN
    logic [63:0] xa, xb, p;
    xa = (f == 2'b11) ? {32'h0, a} : {{32{a[31]}}, a};
    xb = f[1] ? {32'h0, b} : {{32{b[31]}}, b};
    p = xa * xb;
    return (f == 2'b00) ? p[31:0] : p[63:32];
`else
    return a * b;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        last_rst = cyc;
        iv[cyc] = 1'b0;
      end else begin
        iv[cyc] = bus.Mul_Valid;
        ird[cyc] = bus.Mul_Rd;
        ires[cyc] = ref_res(bus.Mul_Funct3, bus.Mul_Rs1, bus.Mul_Rs2);
      end
    end
  end

  initial begin : compare
    bit ev [1:3];
    logic [4:0] er [1:3];
    int n, e;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        n = 0;
        for (int k = 1; k <= 3; k++) begin
          e = cyc - k + 1;
          ev[k] = (e >= 1) && (e > last_rst) && iv[e];
          er[k] = (e >= 1) ? ird[e] : 5'd0;
          n += ev[k] ? 1 : 0;
        end
        chk("m_p1_regmul", bus.P1_RegMul, ev[1]);
        chk("m_p2_regmul", bus.P2_RegMul, ev[2]);
        chk("m_p3_regmul", bus.P3_RegMul, ev[3]);
        if (ev[1]) chk("m_p1_rd", bus.P1_Rd, er[1]);
        if (ev[2]) chk("m_p2_rd", bus.P2_Rd, er[2]);
        if (ev[3]) begin
          chk("m_p3_rd", bus.P3_Rd, er[3]);
          chk("m_wb_rd", bus.Mul_WB_Rd, er[3]);
          chk("m_wb_data", bus.Mul_WB_Data, ires[cyc-2]);
        end
        chk("m_we", bus.Mul_WE, ev[3] && (er[3] != 5'd0));
        chk("m_inflight", bus.Mul_InFlight, n);
        chk("m_busy", bus.Mul_Busy, n != 0);
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    bus.Mul_Valid = v;
    bus.Mul_Funct3 = f;
    bus.Mul_Rs1 = a;
    bus.Mul_Rs2 = b;
    bus.Mul_Rd = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic flags(input string nm, input logic e1, input logic e2, input logic e3);
    chk({nm, "_p1"}, bus.P1_RegMul, e1);
    chk({nm, "_p2"}, bus.P2_RegMul, e2);
    chk({nm, "_p3"}, bus.P3_RegMul, e3);
  endtask

  // Single isolated op: stage flags pulse in sequence, writeback visible after the third edge.
  task automatic run_one(input string nm, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    drive(1'b1, f, a, b, rd);
    tick();
    flags({nm, "_c1"}, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    flags({nm, "_c2"}, 1'b0, 1'b1, 1'b0);
    tick();
    flags({nm, "_c3"}, 1'b0, 1'b0, 1'b1);
    chk({nm, "_we"}, bus.Mul_WE, rd != 5'd0);
    chk({nm, "_wbrd"}, bus.Mul_WB_Rd, rd);
    chk({nm, "_data"}, bus.Mul_WB_Data, exp);
    tick();
    flags({nm, "_c4"}, 1'b0, 1'b0, 1'b0);
    chk({nm, "_we_off"}, bus.Mul_WE, 1'b0);
  endtask

  typedef struct {
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } vec_t;

  vec_t tbl [8] = '{
    '{2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd4},
    '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 5'd9},
    '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12},
    '{2'b11, 32'h8000_0000, 32'h8000_0000, 5'd31},
    '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd17},
    '{2'b10, 32'h0001_0000, 32'h8000_0001, 5'd0},
    '{2'b00, 32'hDEAD_BEEF, 32'h0000_0000, 5'd21},
    '{2'b11, 32'hCAFE_F00D, 32'h1357_9BDF, 5'd30}
  };

  int exp_if [6] = '{1, 2, 3, 2, 1, 0};
  int exp_we [6] = '{0, 0, 1, 1, 1, 0};
  int exp_wr [6] = '{0, 0, 1, 2, 3, 0};

  initial begin
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flags("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_p1_rd", bus.P1_Rd, 5'd0);
    chk("rst_p2_rd", bus.P2_Rd, 5'd0);
    chk("rst_p3_rd", bus.P3_Rd, 5'd0);
    chk("rst_wb_data", bus.Mul_WB_Data, 32'h0);
    chk("rst_we", bus.Mul_WE, 1'b0);
    chk("rst_busy", bus.Mul_Busy, 1'b0);
    chk("rst_inflight", bus.Mul_InFlight, 2'd0);
    reset = 1'b0;

    run_one("mul_neg", 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
`ifdef MUL_HIGH_EN
    run_one("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000);
    run_one("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE);
    run_one("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF);
`else
    run_one("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h0000_0000);
    run_one("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001);
    run_one("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'h0000_0001);
`endif
    run_one("rd0", 2'b00, 32'h0000_0005, 32'h0000_0005, 5'd0, 32'h0000_0019);

    // Three back-to-back issues then idle.
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1'b1, 2'b00, i + 1, 32'd10, i + 1);
      else drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      tick();
      chk("b2b_inflight", bus.Mul_InFlight, exp_if[i]);
      chk("b2b_we", bus.Mul_WE, exp_we[i]);
      if (exp_we[i] != 0) chk("b2b_wbrd", bus.Mul_WB_Rd, exp_wr[i]);
    end

    // Mixed directed vectors back-to-back; the model checks every stage.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd);
      tick();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    repeat (4) tick();

    // Two ops in flight, then reset with a same-edge issue.
    drive(1'b1, 2'b00, 32'd3, 32'd4, 5'd9);
    tick();
    drive(1'b1, 2'b00, 32'd5, 32'd6, 5'd10);
    tick();
    reset = 1'b1;
    drive(1'b1, 2'b00, 32'd7, 32'd8, 5'd11);
    tick();
    flags("flush", 1'b0, 1'b0, 1'b0);
    chk("flush_busy", bus.Mul_Busy, 1'b0);
    chk("flush_inflight", bus.Mul_InFlight, 2'd0);
    reset = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      chk("flush_no_we", bus.Mul_WE, 1'b0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
